// File: rtl/alu_operand_sequencer.sv
// Operand sequencer for the 8-bit ALU core. It gathers A, B and an opcode
// from a byte stream, issues them to the ALU with a start pulse, and returns
// the result and flags on a valid/ready port. Chained commands reuse the
// previous result as A, and a watchdog aborts a command whose done never comes.
module alu_operand_sequencer #(
   parameter int OP_W    = 4,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [7:0]      in_data,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [7:0]      alu_a,
   output logic [7:0]      alu_b,
   output logic [OP_W-1:0] alu_op,
   output logic            alu_start,
   input  logic [7:0]      alu_result,
   input  logic [3:0]      alu_flags,
   input  logic            alu_done,
   output logic [7:0]      out_data,
   output logic [3:0]      out_flags,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            busy,
   output logic            err
);

   typedef enum logic [2:0] {
      LOAD_A, LOAD_B, LOAD_OP, ISSUE, WAIT, OUTPUT
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

   state_t           state, state_nxt;
   logic             chain;
   logic [CNT_W-1:0] cnt;

   // Opcode bits between OP_W and the chain bit carry no meaning.
   logic unused_op_bits;
   assign unused_op_bits = ^in_data[6:OP_W];

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= LOAD_A;
      else     state <= state_nxt;
   end

   // Next-state and handshake/strobe decode. in_ready depends only on state,
   // so in the LOAD states in_valid alone marks a transfer.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      alu_start = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         LOAD_A: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = LOAD_B;
         end
         LOAD_B: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = LOAD_OP;
         end
         LOAD_OP: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = ISSUE;
         end
         ISSUE: begin
            alu_start = 1'b1;
            busy      = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            busy = 1'b1;
            // done beats the watchdog when both land on the last cycle
            if (alu_done)             state_nxt = OUTPUT;
            else if (cnt == LAST_CNT) state_nxt = LOAD_A;
         end
         OUTPUT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_nxt = chain ? LOAD_B : LOAD_A;
         end
         default: state_nxt = LOAD_A;
      endcase
   end

   // Operand, result, chain, watchdog and error registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= '0;
         out_data  <= '0;
         out_flags <= '0;
         chain     <= 1'b0;
         cnt       <= '0;
         err       <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            LOAD_A:  if (in_valid) alu_a <= in_data;
            LOAD_B:  if (in_valid) alu_b <= in_data;
            LOAD_OP: if (in_valid) begin
               alu_op <= in_data[OP_W-1:0];
               chain  <= in_data[7];
            end
            ISSUE:   cnt <= '0;
            WAIT: begin
               if (alu_done) begin
                  out_data  <= alu_result;
                  out_flags <= alu_flags;
               end else if (cnt == LAST_CNT) begin
                  err   <= 1'b1;
                  chain <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            OUTPUT:  if (out_ready && chain) alu_a <= out_data;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer; the bench plays the ALU by hand.
module tb_alu_operand_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] alu_a, alu_b;
   logic [3:0] alu_op;
   logic       alu_start;
   logic [7:0] alu_result = '0;
   logic [3:0] alu_flags = '0;
   logic       alu_done = 1'b0;
   logic [7:0] out_data;
   logic [3:0] out_flags;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       busy, err;

   int vectors = 0;
   int miscompares = 0;
   int start_cnt = 0;
   int xfer_cnt = 0;

   alu_operand_sequencer #(.OP_W(4), .TIMEOUT(16), .CNT_W(5)) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
      .alu_result(alu_result), .alu_flags(alu_flags), .alu_done(alu_done),
      .out_data(out_data), .out_flags(out_flags), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // Count issue pulses and result transfers at each edge.
   always @(posedge clk) begin
      if (alu_start) start_cnt++;
      if (out_valid && out_ready) xfer_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && n < 40) begin
         tick();
         n++;
      end
      vectors++;
      if (!in_ready) begin
         $display("FAIL send_byte: in_ready got 0 want 1 within 40 cycles (byte %h)", b);
         miscompares++;
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      vectors++;
      if ({in_ready, busy, alu_start, out_valid, err} !== 5'b10000) begin
         $display("FAIL reset_ctl: got %b want 10000", {in_ready, busy, alu_start, out_valid, err});
         miscompares++;
      end
      vectors++;
      if ({alu_a, alu_b, alu_op, out_data, out_flags} !== 32'h0) begin
         $display("FAIL reset_data: got %h want 0", {alu_a, alu_b, alu_op, out_data, out_flags});
         miscompares++;
      end
   endtask

   task automatic test_basic();
      int s0 = start_cnt;
      int x0 = xfer_cnt;
      send_byte(8'h12); send_byte(8'h34); send_byte(8'h00);
      vectors++;
      if ({alu_start, alu_a, alu_b, alu_op, in_ready, busy} !== {1'b1, 8'h12, 8'h34, 4'h0, 1'b0, 1'b1}) begin
         $display("FAIL basic_issue: got %h want %h", {alu_start, alu_a, alu_b, alu_op, in_ready, busy},
                  {1'b1, 8'h12, 8'h34, 4'h0, 1'b0, 1'b1});
         miscompares++;
      end
      tick();
      vectors++;
      if ({alu_start, in_ready, out_valid, busy} !== 4'b0001) begin
         $display("FAIL basic_wait: got %b want 0001", {alu_start, in_ready, out_valid, busy});
         miscompares++;
      end
      alu_result = 8'h46; alu_flags = 4'h0; alu_done = 1'b1;
      tick();
      alu_done = 1'b0;
      vectors++;
      if ({out_valid, out_data, out_flags, in_ready} !== {1'b1, 8'h46, 4'h0, 1'b0}) begin
         $display("FAIL basic_out: got %h want %h", {out_valid, out_data, out_flags, in_ready}, {1'b1, 8'h46, 4'h0, 1'b0});
         miscompares++;
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      vectors++;
      if ({out_valid, in_ready, busy} !== 3'b010) begin
         $display("FAIL basic_after: got %b want 010", {out_valid, in_ready, busy});
         miscompares++;
      end
      vectors++;
      if ((start_cnt - s0) != 1 || (xfer_cnt - x0) != 1) begin
         $display("FAIL basic_counts: starts %0d xfers %0d want 1 1", start_cnt - s0, xfer_cnt - x0);
         miscompares++;
      end
   endtask

   task automatic test_chain();
      send_byte(8'h05); send_byte(8'h03); send_byte(8'h81);
      vectors++;
      if ({alu_start, alu_a, alu_b, alu_op} !== {1'b1, 8'h05, 8'h03, 4'h1}) begin
         $display("FAIL chain_issue1: got %h want %h", {alu_start, alu_a, alu_b, alu_op}, {1'b1, 8'h05, 8'h03, 4'h1});
         miscompares++;
      end
      tick();
      alu_result = 8'h08; alu_flags = 4'h0; alu_done = 1'b1;
      tick();
      alu_done = 1'b0; out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      vectors++;
      if ({in_ready, alu_a} !== {1'b1, 8'h08}) begin
         $display("FAIL chain_reload: got %h want %h", {in_ready, alu_a}, {1'b1, 8'h08});
         miscompares++;
      end
      send_byte(8'h02); send_byte(8'h01);
      vectors++;
      if ({alu_start, alu_a, alu_b, alu_op} !== {1'b1, 8'h08, 8'h02, 4'h1}) begin
         $display("FAIL chain_issue2: got %h want %h", {alu_start, alu_a, alu_b, alu_op}, {1'b1, 8'h08, 8'h02, 4'h1});
         miscompares++;
      end
      tick();
      alu_result = 8'h0A; alu_done = 1'b1;
      tick();
      alu_done = 1'b0; out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int x0;
      logic bad = 1'b0;
      // upper opcode bits 6:4 set, so only the low nibble reaches the ALU
      send_byte(8'h10); send_byte(8'h20); send_byte(8'h72);
      vectors++;
      if (alu_op !== 4'h2) begin
         $display("FAIL bp_opmask: got %h want 2", alu_op);
         miscompares++;
      end
      tick();
      alu_result = 8'h30; alu_flags = 4'h4; alu_done = 1'b1;
      tick();
      alu_done = 1'b0;
      x0 = xfer_cnt;
      for (int i = 0; i < 10; i++) begin
         if ({out_valid, out_data, out_flags, in_ready} !== {1'b1, 8'h30, 4'h4, 1'b0}) bad = 1'b1;
         // ALU activity while holding must not disturb the held result
         alu_result = 8'hFF; alu_flags = 4'hF; alu_done = (i == 4);
         tick();
      end
      alu_done = 1'b0;
      vectors++;
      if (bad !== 1'b0 || {out_data, out_flags} !== {8'h30, 4'h4}) begin
         $display("FAIL bp_hold: got %h unstable=%b want 304 stable", {out_data, out_flags}, bad);
         miscompares++;
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tick(); tick();
      vectors++;
      if ({out_valid, in_ready} !== 2'b01 || (xfer_cnt - x0) != 1) begin
         $display("FAIL bp_release: got v/r %b xfers %0d want 01 and 1", {out_valid, in_ready}, xfer_cnt - x0);
         miscompares++;
      end
   endtask

   task automatic test_timeout();
      int s0;
      logic bad = 1'b0;
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h83);
      tick();                      // first WAIT cycle
      for (int i = 1; i < 16; i++) begin
         tick();
         if (err !== 1'b0 || out_valid !== 1'b0) bad = 1'b1;
      end
      vectors++;
      if (bad !== 1'b0) begin
         $display("FAIL to_early: got early err/out_valid want none");
         miscompares++;
      end
      tick();                      // 16 cycles after entering WAIT
      vectors++;
      if ({err, in_ready, busy, out_valid} !== 4'b1100) begin
         $display("FAIL to_err: got %b want 1100", {err, in_ready, busy, out_valid});
         miscompares++;
      end
      s0 = start_cnt;
      alu_done = 1'b1;             // stray done in LOAD_A
      tick();
      alu_done = 1'b0;
      tick();
      vectors++;
      if ({err, in_ready, busy, out_valid} !== 4'b0100 || start_cnt != s0) begin
         $display("FAIL to_after: got %b starts+%0d want 0100 +0", {err, in_ready, busy, out_valid}, start_cnt - s0);
         miscompares++;
      end
   endtask

   task automatic test_collision();
      logic bad = 1'b0;
      // previous command was chained and timed out, so A must be taken fresh
      send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h04);
      vectors++;
      if ({alu_a, alu_b, alu_op} !== {8'h0A, 8'h0B, 4'h4}) begin
         $display("FAIL col_issue: got %h want %h", {alu_a, alu_b, alu_op}, {8'h0A, 8'h0B, 4'h4});
         miscompares++;
      end
      tick();
      for (int i = 1; i < 16; i++) begin
         tick();
         if (err !== 1'b0) bad = 1'b1;
      end
      alu_result = 8'h15; alu_flags = 4'h8; alu_done = 1'b1;   // 16th WAIT cycle
      tick();
      alu_done = 1'b0;
      vectors++;
      if (bad !== 1'b0 || {err, out_valid, out_data, out_flags} !== {1'b0, 1'b1, 8'h15, 4'h8}) begin
         $display("FAIL col_result: got %h early=%b want %h", {err, out_valid, out_data, out_flags}, bad,
                  {1'b0, 1'b1, 8'h15, 4'h8});
         miscompares++;
      end
      tick();
      vectors++;
      if (err !== 1'b0) begin
         $display("FAIL col_noerr: got %b want 0", err);
         miscompares++;
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h85);
      tick();                      // WAIT
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vectors++;
      if ({in_ready, busy, alu_start, out_valid, err, alu_a, alu_b, alu_op, out_data, out_flags} !== {5'b10000, 32'h0}) begin
         $display("FAIL rst_wait: got %h want %h", {in_ready, busy, alu_start, out_valid, err, alu_a, alu_b, alu_op,
                  out_data, out_flags}, {5'b10000, 32'h0});
         miscompares++;
      end
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h85);
      tick();
      alu_result = 8'h33; alu_flags = 4'h1; alu_done = 1'b1;
      tick();
      alu_done = 1'b0;
      rst = 1'b1;                  // reset while in OUTPUT
      tick();
      rst = 1'b0;
      vectors++;
      if ({in_ready, busy, alu_start, out_valid, err, alu_a, alu_b, alu_op, out_data, out_flags} !== {5'b10000, 32'h0}) begin
         $display("FAIL rst_out: got %h want %h", {in_ready, busy, alu_start, out_valid, err, alu_a, alu_b, alu_op,
                  out_data, out_flags}, {5'b10000, 32'h0});
         miscompares++;
      end
      send_byte(8'h07); send_byte(8'h06); send_byte(8'h02);
      vectors++;
      if ({alu_start, alu_a, alu_b, alu_op} !== {1'b1, 8'h07, 8'h06, 4'h2}) begin
         $display("FAIL rst_next_issue: got %h want %h", {alu_start, alu_a, alu_b, alu_op}, {1'b1, 8'h07, 8'h06, 4'h2});
         miscompares++;
      end
      tick();
      alu_result = 8'h2A; alu_flags = 4'h0; alu_done = 1'b1;
      tick();
      alu_done = 1'b0;
      vectors++;
      if ({out_valid, out_data} !== {1'b1, 8'h2A}) begin
         $display("FAIL rst_next_out: got %h want %h", {out_valid, out_data}, {1'b1, 8'h2A});
         miscompares++;
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      vectors++;
      if ({out_valid, in_ready, busy} !== 3'b010) begin
         $display("FAIL rst_next_done: got %b want 010", {out_valid, in_ready, busy});
         miscompares++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_chain();
      test_backpressure();
      test_timeout();
      test_collision();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
